// File: rtl/pixel_fetch_sequencer_pkg.sv
// Shared types and widths for the framebuffer pixel fetch path.
package pixel_fetch_pkg;

    localparam int ADDR_W = 9;
    localparam int PIX_W  = 4;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        CAP
    } fetch_state_t;

endpackage

// File: rtl/pixel_fetch_sequencer_fifo.sv
// Small synchronous show-ahead FIFO with flush; head reads as zero when empty.
module nibble_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W:0]   r_wr;
    logic [PTR_W:0]   r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                     (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);

    // Full is judged on pre-pop occupancy, so a simultaneous pop never frees room.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (PTR_W+1)'(1);
            if (w_pop)  r_rd <= r_rd + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[PTR_W-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd[PTR_W-1:0]];

endmodule

// File: rtl/pixel_fetch_sequencer.sv
// Fetches one framebuffer row per line_start, nibble by nibble, into a show-ahead
// pixel FIFO; also owns row/repeat counting and frame-aligned bank selection.
module pixel_fetch_sequencer
    import pixel_fetch_pkg::*;
#(
    parameter int SAMPLE_DLY     = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int WORDS_PER_LINE = 8,
    parameter int ROWS           = 48,
    parameter int LINE_REPEAT    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              bank_swap_req,
    input  logic              pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic [ADDR_W-1:0] addr,
    output logic              bank,
    output logic [SEL_W-1:0]  pix_sel,
    input  logic [PIX_W-1:0]  pixel_in
);

    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int REP_W  = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
    localparam int WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int WAIT_W = $clog2(SAMPLE_DLY + 2);

    fetch_state_t      r_state;
    fetch_state_t      w_next;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  r_fetch_row;
    logic [ROW_W-1:0]  w_row_base;
    logic [REP_W-1:0]  r_rep;
    logic [REP_W-1:0]  w_rep_base;
    logic [WORD_W-1:0] r_word;
    logic [SEL_W-1:0]  r_nib;
    logic [SEL_W-1:0]  r_pix_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [WAIT_W-1:0] r_wait;
    logic              r_bank;
    logic              r_underflow;
    logic              w_flush;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_last;

    assign w_flush = frame_start | line_start;
    assign w_push  = (r_state == CAP) && !w_full && !w_flush;
    assign w_last  = (r_word == WORD_W'(WORDS_PER_LINE - 1)) && (r_nib == '1);

    // A coincident frame_start zeroes row/rep before line_start consumes them.
    assign w_row_base = frame_start ? '0 : r_row;
    assign w_rep_base = frame_start ? '0 : r_rep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (line_start) begin
            w_next = ADDR;
        end else if (frame_start) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                ADDR:    w_next = (SAMPLE_DLY == 0) ? CAP : WAIT;
                WAIT:    if (r_wait == WAIT_W'(1)) w_next = CAP;
                CAP:     if (w_push) w_next = w_last ? IDLE : ADDR;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_rep       <= '0;
            r_fetch_row <= '0;
            r_word      <= '0;
            r_nib       <= '0;
            r_pix_sel   <= '0;
            r_addr      <= '0;
            r_wait      <= '0;
            r_bank      <= 1'b0;
        end else begin
            if (frame_start) begin
                r_row <= '0;
                r_rep <= '0;
                if (bank_swap_req) r_bank <= ~r_bank;
            end
            if (line_start) begin
                r_fetch_row <= w_row_base;
                r_word      <= '0;
                r_nib       <= '0;
                r_pix_sel   <= '0;
                if (w_rep_base == REP_W'(LINE_REPEAT - 1)) begin
                    r_rep <= '0;
                    r_row <= (w_row_base == ROW_W'(ROWS - 1)) ? '0 : w_row_base + ROW_W'(1);
                end else begin
                    r_rep <= w_rep_base + REP_W'(1);
                end
            end else if (!frame_start) begin
                case (r_state)
                    ADDR: begin
                        r_addr    <= ADDR_W'(32'(r_fetch_row) * WORDS_PER_LINE + 32'(r_word));
                        r_pix_sel <= r_nib;
                        r_wait    <= WAIT_W'(SAMPLE_DLY);
                    end
                    WAIT: r_wait <= r_wait - WAIT_W'(1);
                    CAP: begin
                        if (w_push) begin
                            r_nib <= r_nib + SEL_W'(1);
                            if (r_nib == '1) r_word <= r_word + WORD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_underflow <= 1'b0;
        else if (frame_start)      r_underflow <= 1'b0;
        else if (pop && w_empty)   r_underflow <= 1'b1;
    end

    nibble_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (pop),
        .i_data  (pixel_in),
        .o_data  (pix_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign pix_valid = !w_empty;
    assign underflow = r_underflow;
    assign addr      = r_addr;
    assign bank      = r_bank;
    assign pix_sel   = r_pix_sel;

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Directed bench for pixel_fetch_sequencer with a 2-cycle-latency memory model.
module tb_pixel_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       line_start;
    logic       bank_swap_req;
    logic       pop;
    logic [3:0] pix_data;
    logic       pix_valid;
    logic       underflow;
    logic [8:0] addr;
    logic       bank;
    logic [2:0] pix_sel;
    logic [3:0] pixel_in;

    logic [3:0] m_d1;
    logic [3:0] m_d2;

    int   vectors;
    int   miscompares;
    logic exp_bank;

    pixel_fetch_sequencer #(
        .SAMPLE_DLY     (2),
        .FIFO_DEPTH     (8),
        .WORDS_PER_LINE (8),
        .ROWS           (48),
        .LINE_REPEAT    (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .bank_swap_req (bank_swap_req),
        .pop           (pop),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .underflow     (underflow),
        .addr          (addr),
        .bank          (bank),
        .pix_sel       (pix_sel),
        .pixel_in      (pixel_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: nibble = addr[3:0] ^ pix_sel, valid two clocks after the address.
    always @(posedge clk) begin
        m_d1 <= addr[3:0] ^ {1'b0, pix_sel};
        m_d2 <= m_d1;
    end
    assign pixel_in = m_d2;

    task automatic pulse(input logic fs, input logic ls, input logic swap);
        frame_start   = fs;
        line_start    = ls;
        bank_swap_req = swap;
        @(negedge clk);
        frame_start   = 1'b0;
        line_start    = 1'b0;
        bank_swap_req = 1'b0;
    endtask

    task automatic collect(input int base, input int n);
        int got;
        int waited;
        logic [3:0] e;
        got = 0;
        waited = 0;
        while (got < n && waited < 400) begin
            if (pix_valid) begin
                e = 4'(((base + got / 8) % 16) ^ (got % 8));
                vectors++;
                if (pix_data !== e) begin
                    miscompares++;
                    $display("FAIL pixel base=%0d idx=%0d: got %0h expected %0h", base, got, pix_data, e);
                end
                pop = 1'b1;
                got++;
            end else begin
                pop = 1'b0;
            end
            @(negedge clk);
            waited++;
        end
        pop = 1'b0;
        if (got < n) begin
            vectors++;
            miscompares++;
            $display("FAIL collect_timeout base=%0d: got %0d pixels expected %0d", base, got, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        frame_start = 1'b0;
        line_start = 1'b0;
        bank_swap_req = 1'b0;
        pop = 1'b0;
        #22 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if ({pix_data, pix_valid, underflow, addr, bank, pix_sel} !== 19'd0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %0h expected 0", i,
                         {pix_data, pix_valid, underflow, addr, bank, pix_sel});
            end
        end
    endtask

    task automatic test_fill;
        int n;
        pulse(1'b1, 1'b1, 1'b0);
        n = 0;
        while (!pix_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL first_push_latency: got %0d expected 4", n);
        end
        vectors++;
        if (pix_data !== 4'h0) begin
            miscompares++;
            $display("FAIL first_pixel: got %0h expected 0", pix_data);
        end
        repeat (40) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({pix_valid, addr, pix_sel} !== {1'b1, 9'd1, 3'd0}) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%0b addr=%0d sel=%0d expected valid=1 addr=1 sel=0",
                         pix_valid, addr, pix_sel);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (pix_data !== 4'(i)) begin
                miscompares++;
                $display("FAIL fill_order %0d: got %0h expected %0h", i, pix_data, i);
            end
            pop = 1'b1;
            @(negedge clk);
        end
        pop = 1'b0;
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_underflow: got %0b expected 0", underflow);
        end
    endtask

    task automatic test_stream;
        int base;
        for (int l = 1; l <= 11; l++) begin
            base = (l <= 10) ? 0 : 8;
            pulse(l == 1, 1'b1, 1'b0);
            collect(base, 64);
            vectors++;
            if ({pix_valid, addr, pix_sel} !== {1'b0, 9'(base + 7), 3'd7}) begin
                miscompares++;
                $display("FAIL line_end %0d: got valid=%0b addr=%0d sel=%0d expected valid=0 addr=%0d sel=7",
                         l, pix_valid, addr, pix_sel, base + 7);
            end
        end
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_underflow: got %0b expected 0", underflow);
        end
    endtask

    task automatic test_underflow;
        int n;
        pulse(1'b1, 1'b1, 1'b0);
        n = 0;
        while (!pix_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        pop = 1'b1;
        @(negedge clk);
        vectors++;
        if ({pix_valid, underflow} !== 2'b00) begin
            miscompares++;
            $display("FAIL uf_before: got valid=%0b uf=%0b expected 0 0", pix_valid, underflow);
        end
        @(negedge clk);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_set: got %0b expected 1", underflow);
        end
        repeat (50) @(negedge clk);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_sticky: got %0b expected 1", underflow);
        end
        pop = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_line_start: got %0b expected 1", underflow);
        end
        pulse(1'b1, 1'b0, 1'b0);
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_clear: got %0b expected 0", underflow);
        end
    endtask

    task automatic test_bank;
        int busy;
        exp_bank = 1'b0;
        vectors++;
        if (bank !== exp_bank) begin
            miscompares++;
            $display("FAIL bank_initial: got %0b expected %0b", bank, exp_bank);
        end
        pulse(1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b1);
        exp_bank = ~exp_bank;
        vectors++;
        if ({bank, pix_valid} !== {exp_bank, 1'b0}) begin
            miscompares++;
            $display("FAIL bank_swap: got bank=%0b valid=%0b expected bank=%0b valid=0", bank, pix_valid, exp_bank);
        end
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid) busy++;
        end
        vectors++;
        if (busy !== 0) begin
            miscompares++;
            $display("FAIL frame_abort_idle: got %0d valid cycles expected 0", busy);
        end
        pulse(1'b1, 1'b0, 1'b0);
        vectors++;
        if (bank !== exp_bank) begin
            miscompares++;
            $display("FAIL bank_no_swap: got %0b expected %0b", bank, exp_bank);
        end
        bank_swap_req = 1'b1;
        repeat (10) @(negedge clk);
        bank_swap_req = 1'b0;
        vectors++;
        if (bank !== exp_bank) begin
            miscompares++;
            $display("FAIL bank_req_only: got %0b expected %0b", bank, exp_bank);
        end
    endtask

    task automatic test_abort;
        pulse(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulse(1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        collect(0, 13);
        pulse(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({pix_valid, pix_sel} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_flush: got valid=%0b sel=%0d expected valid=0 sel=0", pix_valid, pix_sel);
        end
        @(negedge clk);
        vectors++;
        if ({addr, pix_sel} !== {9'd8, 3'd0}) begin
            miscompares++;
            $display("FAIL abort_addr: got addr=%0d sel=%0d expected addr=8 sel=0", addr, pix_sel);
        end
        collect(8, 64);
    endtask

    task automatic test_async_reset;
        pulse(1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        vectors++;
        if ({bank, pix_valid, addr} !== {exp_bank, 1'b1, 9'd1}) begin
            miscompares++;
            $display("FAIL pre_reset: got bank=%0b valid=%0b addr=%0d expected bank=%0b valid=1 addr=1",
                     bank, pix_valid, addr, exp_bank);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({pix_data, pix_valid, underflow, addr, bank, pix_sel} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %0h expected 0", {pix_data, pix_valid, underflow, addr, bank, pix_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_bank = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_bank = 1'b0;
        test_reset;
        test_fill;
        test_stream;
        test_underflow;
        test_bank;
        test_abort;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
